// File: rtl/fp_uart_pkg.sv
// Shared definitions for the UART-to-FP command path: opcode bytes, operation
// encodings, assembler states and opcode decode helpers.
package fp_uart_pkg;

    localparam int OPERAND_BYTES = 4;

    localparam logic [7:0] OPC_ADD = 8'h01;
    localparam logic [7:0] OPC_SUB = 8'h02;
    localparam logic [7:0] OPC_MUL = 8'h03;
    localparam logic [7:0] OPC_DIV = 8'h04;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        IDLE,
        OPA,
        OPB,
        HOLD
    } state_e;

    function automatic logic opcode_ok(input logic [7:0] b);
        return (b >= OPC_ADD) && (b <= OPC_DIV);
    endfunction

    function automatic cmd_op_e opcode_to_op(input logic [7:0] b);
        case (b)
            OPC_SUB: return OP_SUB;
            OPC_MUL: return OP_MUL;
            OPC_DIV: return OP_DIV;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/fp_cmd_assembler_if.sv
// Byte-in / command-out bundle of the assembler. The master modport is the
// assembler side; the slave modport is the UART receiver plus FP unit side.
interface fp_cmd_assembler_if;
    import fp_uart_pkg::*;

    logic        rx_byte_valid;
    logic [7:0]  rx_byte;
    logic        cmd_valid;
    logic        cmd_ready;
    cmd_op_e     cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    modport master (
        input  rx_byte_valid, rx_byte, cmd_ready,
        output cmd_valid, cmd_op, cmd_a, cmd_b, frame_err, overrun, busy
    );

    modport slave (
        output rx_byte_valid, rx_byte, cmd_ready,
        input  cmd_valid, cmd_op, cmd_a, cmd_b, frame_err, overrun, busy
    );

endinterface

// File: rtl/byte_timeout_timer.sv
// Saturating idle-cycle counter; expired is high in the cycle the count sits
// at the limit while running with no byte arriving.
module byte_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (!run || clear) begin
            count_d = '0;
        end else if (count_q != LIMIT) begin
            count_d = count_q + CW'(1);
        end
    end

    // NOTE: sequential state is written only with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = run && !clear && (count_q == LIMIT);

endmodule

// File: rtl/fp_cmd_assembler.sv
// Assembles 9-byte UART frames (opcode, operand A, operand B, MSB first) into
// one FP command held on a valid/ready handshake, with inter-byte timeout.
module fp_cmd_assembler
    import fp_uart_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic               clk_100MHz,
    input  logic               reset,
    fp_cmd_assembler_if.master bus
);

    localparam logic [1:0] LAST_IDX = 2'(OPERAND_BYTES - 1);

    state_e      state_q;
    logic [1:0]  idx_q;
    logic [23:0] shreg_q;
    cmd_op_e     op_q;
    logic [31:0] a_q, b_q;
    logic        valid_q, frame_err_q, overrun_q;

    logic        run, clear, expired;
    logic        start_ok;
    logic [31:0] operand_next;

    // shreg_q keeps the earlier bytes of the operand; the incoming byte completes it.
    assign operand_next = {shreg_q, bus.rx_byte};
    assign start_ok     = bus.rx_byte_valid && opcode_ok(bus.rx_byte);
    assign run          = (state_q == OPA) || (state_q == OPB);
    assign clear        = run && bus.rx_byte_valid;

    byte_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_100MHz(clk_100MHz),
        .reset     (reset),
        .run       (run),
        .clear     (clear),
        .expired   (expired)
    );

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            // NOTE: the operand datapath is reset too, so no stale bytes survive a mid-frame reset.
            state_q     <= IDLE;
            idx_q       <= '0;
            shreg_q     <= '0;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        op_q    <= opcode_to_op(bus.rx_byte);
                        idx_q   <= '0;
                        state_q <= OPA;
                    end else if (bus.rx_byte_valid) begin
                        frame_err_q <= 1'b1;
                    end
                end
                OPA, OPB: begin
                    if (bus.rx_byte_valid) begin
                        shreg_q <= operand_next[23:0];
                        idx_q   <= idx_q + 2'd1;
                        if (idx_q == LAST_IDX) begin
                            if (state_q == OPA) begin
                                a_q     <= operand_next;
                                state_q <= OPB;
                            end else begin
                                b_q     <= operand_next;
                                valid_q <= 1'b1;
                                state_q <= HOLD;
                            end
                        end
                    end else if (expired) begin
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                HOLD: begin
                    // A byte landing on the transfer cycle opens the next frame.
                    if (bus.cmd_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                        if (start_ok) begin
                            op_q    <= opcode_to_op(bus.rx_byte);
                            idx_q   <= '0;
                            state_q <= OPA;
                        end else if (bus.rx_byte_valid) begin
                            frame_err_q <= 1'b1;
                        end
                    end else if (bus.rx_byte_valid) begin
                        overrun_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.cmd_valid = valid_q;
    assign bus.cmd_op    = op_q;
    assign bus.cmd_a     = a_q;
    assign bus.cmd_b     = b_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fp_cmd_assembler.sv
// Directed bench for fp_cmd_assembler: a table of complete frames plus
// hand-written sequences for bad opcodes, timeout, overrun, back-to-back and reset.
module tb_fp_cmd_assembler;
    import fp_uart_pkg::*;

    localparam int unsigned T = 20;

    typedef struct {
        logic [7:0]  opc;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  exp_op;
        int          gap;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[4];

    always #5 clk = ~clk;

    fp_cmd_assembler_if bus();

    fp_cmd_assembler #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_100MHz(clk),
        .reset     (reset),
        .bus       (bus.master)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_byte       = b;
        bus.rx_byte_valid = 1'b1;
        step();
        bus.rx_byte_valid = 1'b0;
    endtask

    task automatic send_operands(input logic [31:0] a, input logic [31:0] b, input int gap);
        for (int i = 3; i >= 0; i--) begin
            repeat (gap) step();
            send_byte(a[i*8 +: 8]);
        end
        for (int i = 3; i >= 0; i--) begin
            repeat (gap) step();
            send_byte(b[i*8 +: 8]);
        end
    endtask

    // Full frame with cmd_ready high: command visible right after byte 9, gone one cycle later.
    task automatic run_frame(input logic [7:0] opc, input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] exp_op, input int gap);
        send_byte(opc);
        check("busy_after_opcode", bus.busy, 1);
        send_operands(a, b, gap);
        check("valid_after_byte9", bus.cmd_valid, 1);
        check("cmd_op", bus.cmd_op, exp_op);
        check("cmd_a", bus.cmd_a, a);
        check("cmd_b", bus.cmd_b, b);
        step();
        check("valid_after_transfer", bus.cmd_valid, 0);
        check("busy_after_transfer", bus.busy, 0);
    endtask

    initial begin
        int n_err;
        int n_valid;
        int n_ovr;
        int fired_at;
        logic stable;

        vecs[0] = '{opc: 8'h01, a: 32'h3F80_0000, b: 32'h4000_0000, exp_op: 2'b00, gap: 0};
        vecs[1] = '{opc: 8'h02, a: 32'hC0A0_0000, b: 32'h3F00_0000, exp_op: 2'b01, gap: 2};
        vecs[2] = '{opc: 8'h03, a: 32'h1234_5678, b: 32'h9ABC_DEF0, exp_op: 2'b10, gap: 1};
        vecs[3] = '{opc: 8'h04, a: 32'hFFFF_FFFF, b: 32'h0000_0001, exp_op: 2'b11, gap: 3};

        reset             = 1'b1;
        bus.rx_byte_valid = 1'b0;
        bus.rx_byte       = 8'h00;
        bus.cmd_ready     = 1'b1;
        repeat (3) step();
        check("rst_cmd_valid", bus.cmd_valid, 0);
        check("rst_cmd_op", bus.cmd_op, 0);
        check("rst_cmd_a", bus.cmd_a, 0);
        check("rst_cmd_b", bus.cmd_b, 0);
        check("rst_frame_err", bus.frame_err, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_busy", bus.busy, 0);
        reset = 1'b0;
        step();

        for (int v = 0; v < 4; v++) begin
            run_frame(vecs[v].opc, vecs[v].a, vecs[v].b, vecs[v].exp_op, vecs[v].gap);
        end

        // Invalid opcode is discarded with a single error pulse.
        send_byte(8'h07);
        check("bad_opc_frame_err", bus.frame_err, 1);
        check("bad_opc_busy", bus.busy, 0);
        step();
        check("bad_opc_pulse_width", bus.frame_err, 0);
        run_frame(8'h03, 32'h4040_0000, 32'h4080_0000, 2'b10, 0);

        // Partial frame then silence: timeout fires after exactly T+1 idle cycles.
        send_byte(8'h02);
        send_byte(8'hC0);
        send_byte(8'hA0);
        n_err = 0;
        n_valid = 0;
        fired_at = -1;
        for (int i = 1; i <= int'(T) + 5; i++) begin
            step();
            if (bus.frame_err) begin
                n_err++;
                if (fired_at < 0) fired_at = i;
            end
            if (bus.cmd_valid) n_valid++;
        end
        check("timeout_err_count", n_err, 1);
        check("timeout_fire_cycle", fired_at, T + 1);
        check("timeout_no_valid", n_valid, 0);
        check("timeout_idle", bus.busy, 0);
        run_frame(8'h01, 32'h3F80_0000, 32'h3F80_0000, 2'b00, 0);

        // Byte arriving on the very cycle the counter hits the limit is kept.
        send_byte(8'h03);
        repeat (T) step();
        send_byte(8'h41);
        check("limit_byte_no_err", bus.frame_err, 0);
        check("limit_byte_busy", bus.busy, 1);
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'hBF);
        send_byte(8'h80);
        send_byte(8'h00);
        send_byte(8'h00);
        check("limit_frame_valid", bus.cmd_valid, 1);
        check("limit_frame_a", bus.cmd_a, 32'h4120_0000);
        check("limit_frame_b", bus.cmd_b, 32'hBF80_0000);
        step();

        // Held command with bytes arriving: overrun pulses, command stays put.
        bus.cmd_ready = 1'b0;
        send_byte(8'h01);
        send_operands(32'h3F80_0000, 32'h4040_0000, 0);
        check("hold_valid", bus.cmd_valid, 1);
        n_ovr = 0;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (i == 10 || i == 20 || i == 30) begin
                send_byte(8'h55);
            end else begin
                step();
            end
            if (bus.overrun) n_ovr++;
            if (!bus.cmd_valid || bus.cmd_op != OP_ADD || bus.cmd_a != 32'h3F80_0000
                || bus.cmd_b != 32'h4040_0000) stable = 1'b0;
        end
        check("overrun_count", n_ovr, 3);
        check("hold_stable", stable, 1);
        bus.cmd_ready = 1'b1;
        step();
        check("hold_released", bus.cmd_valid, 0);
        check("hold_idle", bus.busy, 0);

        // Opcode on the transfer cycle starts the next frame without overrun.
        bus.cmd_ready = 1'b0;
        send_byte(8'h02);
        send_operands(32'h3F80_0000, 32'h3F80_0000, 0);
        step();
        bus.cmd_ready = 1'b1;
        send_byte(8'h04);
        check("b2b_valid_dropped", bus.cmd_valid, 0);
        check("b2b_no_overrun", bus.overrun, 0);
        check("b2b_no_frame_err", bus.frame_err, 0);
        check("b2b_busy", bus.busy, 1);
        send_operands(32'h40A0_0000, 32'h4000_0000, 0);
        check("b2b_valid", bus.cmd_valid, 1);
        check("b2b_op_div", bus.cmd_op, 2'b11);
        check("b2b_a", bus.cmd_a, 32'h40A0_0000);
        check("b2b_b", bus.cmd_b, 32'h4000_0000);
        step();

        // Reset after 5 bytes of a frame, then a clean frame.
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        reset = 1'b1;
        step();
        check("midrst_valid", bus.cmd_valid, 0);
        check("midrst_op", bus.cmd_op, 0);
        check("midrst_a", bus.cmd_a, 0);
        check("midrst_b", bus.cmd_b, 0);
        check("midrst_frame_err", bus.frame_err, 0);
        check("midrst_overrun", bus.overrun, 0);
        check("midrst_busy", bus.busy, 0);
        reset = 1'b0;
        step();
        run_frame(8'h02, 32'h1122_3344, 32'h5566_7788, 2'b01, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
